// File: rtl/instruction_decode.sv
// instruction_decode: decode stage ahead of Execute.
//   Splits a 16-bit instruction, reads an 8x16 register file (write-before-read
//   bypass from the writeback port) and registers control, dest index, operands,
//   NPC and imm7 in the decode/execute register. Detects load-use hazards,
//   inserts a one-cycle bubble and asks fetch to hold via stall_req.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   instr, npc_in, in_valid instruction, next-PC and valid from fetch
//   stall, flush            downstream hold / squash of the instruction in decode
//   wb_en, wb_index, wb_data register-file writeback port
//   control_out .. valid_out registered decode/execute payload
//   stall_req               combinational: fetch must hold its instruction
module instruction_decode #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned IDX_W    = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic [15:0]       npc_in,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [IDX_W-1:0]  wb_index,
   input  logic [DATA_W-1:0] wb_data,
   output logic [4:0]        control_out,
   output logic [IDX_W-1:0]  dest_index_out,
   output logic [DATA_W-1:0] reg1_data,
   output logic [DATA_W-1:0] reg2_data,
   output logic [15:0]       npc_out,
   output logic [6:0]        immediate_out,
   output logic              reg_write_out,
   output logic              valid_out,
   output logic              stall_req
);

   localparam int unsigned OP_W   = 4;
   localparam int unsigned RIDX_W = 3;
   localparam int unsigned CTRL_W = 5;
   localparam int unsigned IMM_W  = 7;
   localparam int unsigned PC_W   = 16;

   localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
   localparam logic [OP_W-1:0] OP_ADDI  = 4'h3;
   localparam logic [OP_W-1:0] OP_SHLLI = 4'h4;
   localparam logic [OP_W-1:0] OP_SHRLI = 4'h5;
   localparam logic [OP_W-1:0] OP_CMP   = 4'hB;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'hC;
   localparam logic [OP_W-1:0] OP_LOADI = 4'hD;
   localparam logic [OP_W-1:0] OP_STORE = 4'hE;
   localparam logic [OP_W-1:0] OP_MOV   = 4'hF;

   localparam logic [CTRL_W-1:0] CTRL_LOAD = {1'b0, OP_LOAD};

   typedef struct packed {
      logic [CTRL_W-1:0] control;
      logic [IDX_W-1:0]  dest;
      logic [DATA_W-1:0] reg1;
      logic [DATA_W-1:0] reg2;
      logic [PC_W-1:0]   npc;
      logic [IMM_W-1:0]  imm;
      logic              reg_write;
      logic              valid;
   } de_t;

   logic [DATA_W-1:0] rf_q   [NUM_REGS];
   logic [DATA_W-1:0] rf_byp [NUM_REGS];
   de_t               de_q, de_d, dec;

   logic [OP_W-1:0]   op;
   logic [RIDX_W-1:0] rd, rs, rt;
   logic              src_rs_rt, src_rd, has_dest, writes_dest;
   logic              hazard;

   assign op = instr[15:12];
   assign rd = instr[11:9];
   assign rs = instr[8:6];
   assign rt = instr[5:3];

   // Register file with writeback; R0 and out-of-range indices are never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wb_en && wb_index != '0 && wb_index < IDX_W'(NUM_REGS)) begin
         rf_q[wb_index[RIDX_W-1:0]] <= wb_data;
      end
   end

   // Read view with same-cycle writeback forwarded; R0 always reads zero.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         rf_byp[i] = rf_q[i];
         if (wb_en && wb_index == IDX_W'(i)) rf_byp[i] = wb_data;
      end
      rf_byp[0] = '0;
   end

   // Opcode classification: which fields are sources, and whether rd is written.
   always_comb begin
      src_rs_rt   = 1'b0;
      src_rd      = 1'b0;
      has_dest    = 1'b0;
      writes_dest = 1'b0;
      case (op)
         OP_SUB, OP_ADD, OP_MOV, OP_LOAD: begin
            src_rs_rt   = 1'b1;
            has_dest    = 1'b1;
            writes_dest = 1'b1;
         end
         OP_CMP: begin
            src_rs_rt = 1'b1;
            has_dest  = 1'b1;
         end
         OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOADI: begin
            src_rd      = 1'b1;
            has_dest    = 1'b1;
            writes_dest = 1'b1;
         end
         OP_STORE: src_rs_rt = 1'b1;
         default: ;
      endcase
   end

   // Decoded payload for the instruction currently presented by fetch.
   always_comb begin
      dec           = '0;
      dec.control   = {1'b0, op};
      dec.dest      = has_dest ? IDX_W'(rd) : '0;
      dec.reg1      = src_rs_rt ? rf_byp[rs] : (src_rd ? rf_byp[rd] : '0);
      dec.reg2      = src_rs_rt ? rf_byp[rt] : '0;
      dec.npc       = npc_in;
      dec.imm       = instr[IMM_W-1:0];
      dec.reg_write = writes_dest;
      dec.valid     = 1'b1;
   end

   // A LOAD sitting in the D/E register whose dest feeds the incoming instruction.
   always_comb begin
      hazard = 1'b0;
      if (de_q.valid && de_q.control == CTRL_LOAD && de_q.reg_write &&
          de_q.dest != '0 && in_valid) begin
         hazard = (src_rs_rt && (IDX_W'(rs) == de_q.dest || IDX_W'(rt) == de_q.dest)) ||
                  (src_rd && IDX_W'(rd) == de_q.dest);
      end
   end

   // Fetch is only told to hold when this edge will actually insert the bubble.
   assign stall_req = hazard && !reset && !flush && !stall;

   // Next D/E contents: flush > stall > load-use bubble > normal load.
   always_comb begin
      de_d = de_q;
      if (flush)                 de_d = '0;
      else if (stall)            de_d = de_q;
      else if (hazard || !in_valid) de_d = '0;
      else                       de_d = dec;
   end

   always_ff @(posedge clk) begin
      if (reset) de_q <= '0;
      else       de_q <= de_d;
   end

   assign control_out    = de_q.control;
   assign dest_index_out = de_q.dest;
   assign reg1_data      = de_q.reg1;
   assign reg2_data      = de_q.reg2;
   assign npc_out        = de_q.npc;
   assign immediate_out  = de_q.imm;
   assign reg_write_out  = de_q.reg_write;
   assign valid_out      = de_q.valid;

endmodule
